// File: rtl/int_ctrl.sv
// int_ctrl: memory-mapped interrupt controller.
// Pends device interrupt lines (edge or level), masks them, applies a global
// enable and presents a registered, lowest-index-wins request/vector to CP0.
module int_ctrl #(
  parameter int N_SRC = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] irq_in,
  input  logic [31:0]      DEV_Addr,
  input  logic [31:0]      DEV_WD,
  input  logic             DEV_WE,
  output logic [31:0]      DEV_RD,
  input  logic             int_ack,
  output logic [N_SRC-1:0] hw_int,
  output logic             int_req,
  output logic [3:0]       int_id
);

  localparam logic [1:0] A_MASK = 2'b00;
  localparam logic [1:0] A_PEND = 2'b01;
  localparam logic [1:0] A_CTRL = 2'b10;
  localparam logic [1:0] A_STAT = 2'b11;

  logic [N_SRC-1:0] mask_q, mask_d;
  logic [N_SRC-1:0] pend_q, pend_d;
  logic             gen_q, gen_d;
  logic             edge_q, edge_d;
  logic [N_SRC-1:0] irq_s_q, irq_d_q;
  logic [N_SRC-1:0] hw_int_q, hw_int_d;
  logic             int_req_q, int_req_d;
  logic [3:0]       int_id_q, int_id_d;

  logic [1:0]       addr;
  logic [N_SRC-1:0] clr;
  logic [N_SRC-1:0] visible;

  // Only the register select bits and the low data bits carry meaning here.
  logic unused_bits;
  assign unused_bits = ^{DEV_Addr[31:4], DEV_Addr[1:0], DEV_WD[31:N_SRC]};

  assign addr = DEV_Addr[3:2];

  // Clear vector: software W1C plus the source CP0 just took (only if a request was up).
  always_comb begin
    clr = '0;
    if (DEV_WE && addr == A_PEND) clr = DEV_WD[N_SRC-1:0];
    if (int_ack && int_req_q) begin
      for (int i = 0; i < N_SRC; i++)
        if (int_id_q == 4'(i)) clr[i] = 1'b1;
    end
  end

  // Next-state for config, pending and the registered CP0 view.
  always_comb begin
    mask_d = mask_q;
    gen_d  = gen_q;
    edge_d = edge_q;
    if (DEV_WE && addr == A_MASK) mask_d = DEV_WD[N_SRC-1:0];
    if (DEV_WE && addr == A_CTRL) begin
      gen_d  = DEV_WD[0];
      edge_d = DEV_WD[1];
    end
    // A new rising edge beats a same-cycle clear; level mode just tracks the line.
    pend_d = edge_q ? ((pend_q & ~clr) | (irq_s_q & ~irq_d_q)) : irq_s_q;

    visible   = gen_q ? (pend_q & mask_q) : '0;
    hw_int_d  = visible;
    int_req_d = |visible;
    int_id_d  = 4'hF;
    for (int i = N_SRC - 1; i >= 0; i--)
      if (visible[i]) int_id_d = 4'(i);
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mask_q    <= '0;
      pend_q    <= '0;
      gen_q     <= 1'b0;
      edge_q    <= 1'b0;
      irq_s_q   <= '0;
      irq_d_q   <= '0;
      hw_int_q  <= '0;
      int_req_q <= 1'b0;
      int_id_q  <= 4'hF;
    end else begin
      mask_q    <= mask_d;
      pend_q    <= pend_d;
      gen_q     <= gen_d;
      edge_q    <= edge_d;
      irq_s_q   <= irq_in;
      irq_d_q   <= irq_s_q;
      hw_int_q  <= hw_int_d;
      int_req_q <= int_req_d;
      int_id_q  <= int_id_d;
    end
  end

  // Combinational register read mux.
  always_comb begin
    DEV_RD = '0;
    case (addr)
      A_MASK: DEV_RD = 32'(mask_q);
      A_PEND: DEV_RD = 32'(pend_q);
      A_CTRL: DEV_RD = {30'b0, edge_q, gen_q};
      A_STAT: DEV_RD = {int_req_q, 23'b0, 4'b0, int_id_q};
      default: DEV_RD = '0;
    endcase
  end

  assign hw_int  = hw_int_q;
  assign int_req = int_req_q;
  assign int_id  = int_id_q;

endmodule

// File: tb/tb_int_ctrl.sv
// tb_int_ctrl: directed + randomized stimulus, reference model feeds a
// scoreboard queue, an independent monitor compares on every falling edge.
module tb_int_ctrl;
  localparam int N = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  irq_in;
  logic [31:0]   DEV_Addr, DEV_WD, DEV_RD;
  logic          DEV_WE, int_ack;
  logic [N-1:0]  hw_int;
  logic          int_req;
  logic [3:0]    int_id;

  always #5 clk = ~clk;

  int_ctrl #(.N_SRC(N)) dut (
    .clk(clk), .reset(reset), .irq_in(irq_in), .DEV_Addr(DEV_Addr),
    .DEV_WD(DEV_WD), .DEV_WE(DEV_WE), .DEV_RD(DEV_RD), .int_ack(int_ack),
    .hw_int(hw_int), .int_req(int_req), .int_id(int_id)
  );

  typedef struct packed {
    logic [N-1:0] hw;
    logic         req;
    logic [3:0]   id;
    logic [31:0]  rd;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model state: what software and CP0 should observe.
  logic [N-1:0] m_mask, m_pend, m_s, m_d, m_hw;
  logic         m_gen, m_edge, m_req;
  logic [3:0]   m_id;
  logic [N-1:0] cur_irq;

  function automatic logic [3:0] lowest(input logic [N-1:0] v);
    logic [3:0] r = 4'hF;
    for (int i = N - 1; i >= 0; i--) if (v[i]) r = 4'(i);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One bus cycle: drive inputs, advance the model, queue what the DUT must show after the edge.
  task automatic cyc(input logic rst, input logic [N-1:0] irq, input logic we,
                     input logic [1:0] a, input logic [31:0] wd, input logic ack);
    logic [N-1:0] clr, vis, npend;
    logic [31:0]  ad;
    exp_t         e;
    @(negedge clk); #1;
    ad       = $urandom;
    ad[3:2]  = a;
    reset    = rst;
    irq_in   = irq;
    DEV_WE   = we;
    DEV_Addr = ad;
    DEV_WD   = wd;
    int_ack  = ack;
    cur_irq  = irq;
    if (!rst) begin
      m_mask = '0; m_pend = '0; m_s = '0; m_d = '0; m_hw = '0;
      m_gen = 1'b0; m_edge = 1'b0; m_req = 1'b0; m_id = 4'hF;
    end else begin
      clr = '0;
      if (we && a == 2'd1) clr = wd[N-1:0];
      if (ack && m_req) clr[m_id] = 1'b1;
      vis   = m_gen ? (m_pend & m_mask) : '0;
      npend = m_edge ? ((m_pend & ~clr) | (m_s & ~m_d)) : m_s;
      m_hw  = vis;
      m_req = (vis != 0);
      m_id  = lowest(vis);
      m_pend = npend;
      if (we && a == 2'd0) m_mask = wd[N-1:0];
      if (we && a == 2'd2) begin m_gen = wd[0]; m_edge = wd[1]; end
      m_d = m_s;
      m_s = irq;
    end
    e.hw  = m_hw;
    e.req = m_req;
    e.id  = m_id;
    case (a)
      2'd0: e.rd = 32'(m_mask);
      2'd1: e.rd = 32'(m_pend);
      2'd2: e.rd = {30'b0, m_edge, m_gen};
      default: e.rd = {m_req, 27'b0, m_id};
    endcase
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, cur_irq, 1'b0, 2'(i), 32'h0, 1'b0);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] wd);
    cyc(1'b1, cur_irq, 1'b1, a, wd, 1'b0);
  endtask

  task automatic ack1();
    cyc(1'b1, cur_irq, 1'b0, 2'd3, 32'h0, 1'b1);
  endtask

  // Monitor: each falling edge shows the result of the preceding rising edge.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("hw_int",  32'(hw_int),  32'(e.hw));
      chk("int_req", 32'(int_req), 32'(e.req));
      chk("int_id",  32'(int_id),  32'(e.id));
      chk("DEV_RD",  DEV_RD,       e.rd);
    end
  end

  initial begin
    reset = 1'b0; irq_in = '0; DEV_Addr = '0; DEV_WD = '0; DEV_WE = 1'b0; int_ack = 1'b0;
    cur_irq = '0;
    m_mask = '0; m_pend = '0; m_s = '0; m_d = '0; m_hw = '0;
    m_gen = 1'b0; m_edge = 1'b0; m_req = 1'b0; m_id = 4'hF;

    // Reset, then read every register.
    cyc(1'b0, '0, 1'b0, 2'd0, 32'h0, 1'b0);
    cyc(1'b0, '0, 1'b0, 2'd3, 32'h0, 1'b0);
    for (int a = 0; a < 4; a++) cyc(1'b1, '0, 1'b0, 2'(a), 32'h0, 1'b0);

    // Single-cycle pulse on source 2, then ack.
    wr(2'd2, 32'h3);
    wr(2'd0, 32'h3F);
    cyc(1'b1, 6'h04, 1'b0, 2'd1, 32'h0, 1'b0);
    cyc(1'b1, 6'h00, 1'b0, 2'd1, 32'h0, 1'b0);
    idle(3);
    ack1();
    idle(3);

    // Two sources together: lowest wins, acks walk through them.
    cur_irq = 6'h12;
    idle(4);
    ack1();
    idle(2);
    ack1();
    idle(3);
    cur_irq = '0;
    idle(2);

    // Masked source still pends; unmasking exposes it; W1C retires it.
    wr(2'd0, 32'h01);
    cur_irq = 6'h08;
    idle(3);
    wr(2'd0, 32'h08);
    idle(3);
    wr(2'd1, 32'h08);
    idle(3);
    cur_irq = '0;
    idle(2);

    // Level mode: ack and W1C do nothing, dropping the line clears.
    wr(2'd2, 32'h1);
    wr(2'd0, 32'h3F);
    cur_irq = 6'h01;
    idle(4);
    ack1();
    wr(2'd1, 32'h01);
    idle(2);
    cur_irq = '0;
    idle(4);

    // Edge mode: W1C of bit 5 coinciding with a fresh edge keeps it pending.
    wr(2'd2, 32'h3);
    cur_irq = 6'h20;
    idle(3);
    cur_irq = '0;
    idle(2);
    cur_irq = 6'h20;
    idle(1);
    wr(2'd1, 32'h20);
    idle(3);
    // Reset while a request is up, level held through reset.
    cyc(1'b0, cur_irq, 1'b0, 2'd3, 32'h0, 1'b0);
    wr(2'd2, 32'h3);
    wr(2'd0, 32'h3F);
    idle(4);
    cur_irq = '0;
    idle(2);

    // Randomized traffic.
    for (int k = 0; k < 1500; k++) begin
      logic [N-1:0] nirq;
      logic         rst, we, ack;
      logic [1:0]   a;
      logic [31:0]  wd;
      nirq = cur_irq;
      for (int b = 0; b < N; b++) if ($urandom_range(7) == 0) nirq[b] = ~nirq[b];
      rst = ($urandom_range(199) != 0);
      we  = ($urandom_range(5) == 0);
      a   = 2'($urandom_range(3));
      wd  = $urandom;
      if (we && a == 2'd2 && $urandom_range(3) != 0) wd[0] = 1'b1;
      ack = m_req ? ($urandom_range(3) == 0) : ($urandom_range(15) == 0);
      cyc(rst, nirq, we, a, wd, ack);
    end

    idle(1);
    @(negedge clk); #1;
    @(negedge clk); #1;
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d queued expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
